// File: rtl/ntt_pkg.sv
// Shared NTT constants and the coefficient type for the radix-4 inverse
// transform block. Default field is Q = 65537 (Fermat prime F4).
package ntt_pkg;

    localparam int unsigned N_DEF      = 17;
    localparam int unsigned Q_DEF      = 65537;
    localparam int unsigned W4_INV_DEF = 65281;   // -256 mod 65537
    localparam int unsigned INV4_DEF   = 49153;   // 4^-1 mod 65537

    typedef logic [N_DEF-1:0] coeff_t;

endpackage

// File: rtl/radix_4_dit_intt_if.sv
// Streaming bus for the radix-4 inverse butterfly: input coefficients and
// twiddles with an in_valid/in_ready pair, results with out_valid/out_ready.
// A beat moves on a rising clock edge where valid and ready are both high;
// a producer holds its valid and data steady until that edge arrives.
interface radix_4_dit_intt_if
    import ntt_pkg::*;
#(
    parameter int unsigned N = N_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a0, a1, a2, a3;
    logic [N-1:0] tf0, tf1, tf2, tf3;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] A0, A1, A2, A3;

    // Upstream/downstream side (drives inputs, accepts results)
    modport master (
        output in_valid, a0, a1, a2, a3, tf0, tf1, tf2, tf3, out_ready,
        input  in_ready, out_valid, A0, A1, A2, A3
    );

    // Transform block side
    modport slave (
        input  in_valid, a0, a1, a2, a3, tf0, tf1, tf2, tf3, out_ready,
        output in_ready, out_valid, A0, A1, A2, A3
    );
endinterface

// File: rtl/mod_mul.sv
// Combinational N x N -> N modular multiply. The full 2N-bit product is
// reduced to [0, Q-1] in the same cycle; operands must already be < Q.
module mod_mul
    import ntt_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned Q = Q_DEF
)(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_p
);
    localparam logic [2*N-1:0] QW = (2*N)'(Q);

    logic [2*N-1:0] w_prod;

    assign w_prod = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
    assign o_p    = N'(w_prod % QW);
endmodule

// File: rtl/radix_4_dit_intt.sv
// Radix-4 decimation-in-time inverse NTT butterfly.
//   stage 1: b_k = a_k * tf_k mod Q (inverse twiddles applied first)
//   stage 2: 4-point butterfly with w = W4_INV
//   stage 3: only with INTT_SCALE_EN defined -- multiply results by 4^-1
// A single stall signal (result held but not taken) freezes every stage,
// valid bits included, so results stay stable until transferred.
module radix_4_dit_intt
    import ntt_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned Q      = Q_DEF,
    parameter int unsigned W4_INV = W4_INV_DEF
`ifdef INTT_SCALE_EN
    ,
    parameter int unsigned INV4   = INV4_DEF
`endif
)(
    input  logic               clk,
    input  logic               rst_n,
    radix_4_dit_intt_if.slave  bus
);
    localparam logic [N:0]   QX  = (N+1)'(Q);
    localparam logic [N-1:0] QN  = N'(Q);
    localparam logic [N-1:0] W_C = N'(W4_INV);

    // Modular add: operands < Q, so one conditional subtract suffices
    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return s[N-1:0];
    endfunction

    // Modular subtract: add Q back when the difference would go negative
    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        if (x >= y) return x - y;
        else        return x + (QN - y);
    endfunction

    logic              w_stall;
    logic              w_out_valid;
    logic [3:0][N-1:0] w_out;

    logic [3:0][N-1:0] w_a;
    logic [3:0][N-1:0] w_tf;
    logic [3:0][N-1:0] w_b;
    logic              r_s1_valid;
    logic [3:0][N-1:0] r_b;

    logic [N-1:0]      w_wb1;
    logic [N-1:0]      w_wb3;
    logic [N-1:0]      w_s02;
    logic [N-1:0]      w_d02;
    logic [N-1:0]      w_s13;
    logic [N-1:0]      w_dw;
    logic [3:0][N-1:0] w_y;
    logic              r_s2_valid;
    logic [3:0][N-1:0] r_y;

    // Stall whenever a result is presented and not taken
    assign w_stall = w_out_valid & ~bus.out_ready;

    assign w_a  = {bus.a3, bus.a2, bus.a1, bus.a0};
    assign w_tf = {bus.tf3, bus.tf2, bus.tf1, bus.tf0};

    for (genvar k = 0; k < 4; k++) begin : g_twiddle
        mod_mul #(.N(N), .Q(Q)) u_tw_mul (
            .i_a (w_a[k]),
            .i_b (w_tf[k]),
            .o_p (w_b[k])
        );
    end

    // Stage 1 register: twiddled coefficients; bubbles pass as valid=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_b        <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) r_b <= w_b;
        end
    end

    mod_mul #(.N(N), .Q(Q)) u_w_mul1 (
        .i_a (r_b[1]),
        .i_b (W_C),
        .o_p (w_wb1)
    );

    mod_mul #(.N(N), .Q(Q)) u_w_mul3 (
        .i_a (r_b[3]),
        .i_b (W_C),
        .o_p (w_wb3)
    );

    // Shared partial terms: A1/A3 differ only in the sign of w*(b1-b3)
    assign w_s02 = mod_add(r_b[0], r_b[2]);
    assign w_d02 = mod_sub(r_b[0], r_b[2]);
    assign w_s13 = mod_add(r_b[1], r_b[3]);
    assign w_dw  = mod_sub(w_wb1, w_wb3);

    assign w_y[0] = mod_add(w_s02, w_s13);
    assign w_y[1] = mod_add(w_d02, w_dw);
    assign w_y[2] = mod_sub(w_s02, w_s13);
    assign w_y[3] = mod_sub(w_d02, w_dw);

    // Stage 2 register: butterfly outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_y <= w_y;
        end
    end

`ifdef INTT_SCALE_EN
    localparam logic [N-1:0] INV4_C = N'(INV4);

    logic              r_s3_valid;
    logic [3:0][N-1:0] w_z;
    logic [3:0][N-1:0] r_z;

    for (genvar k = 0; k < 4; k++) begin : g_scale
        mod_mul #(.N(N), .Q(Q)) u_scale_mul (
            .i_a (r_y[k]),
            .i_b (INV4_C),
            .o_p (w_z[k])
        );
    end

    // Stage 3 register: results scaled by 4^-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_z        <= '0;
        end else if (!w_stall) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) r_z <= w_z;
        end
    end

    assign w_out_valid = r_s3_valid;
    assign w_out       = r_z;
`else
    assign w_out_valid = r_s2_valid;
    assign w_out       = r_y;
`endif

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = w_out_valid;
    assign bus.A0        = w_out[0];
    assign bus.A1        = w_out[1];
    assign bus.A2        = w_out[2];
    assign bus.A3        = w_out[3];
endmodule

// File: tb/tb_radix_4_dit_intt.sv
// Bench for radix_4_dit_intt: directed vectors with hand-computed results,
// a queue-based scoreboard filled on input transfer and drained by a
// monitor on output transfer. Handles the INTT_SCALE_EN build as well.
module tb_radix_4_dit_intt;
    import ntt_pkg::*;

    localparam int N  = 17;
    localparam int W  = 4 * N;
    localparam int NV = 8;
`ifdef INTT_SCALE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    radix_4_dit_intt_if #(.N(N)) bus ();

    radix_4_dit_intt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Directed vectors: a, tf, and the unscaled result A0..A3
    int unsigned vec_a [NV][4] = '{
        '{1, 1, 1, 1}, '{0, 1, 0, 0}, '{65536, 65536, 65536, 65536}, '{2, 0, 0, 0},
        '{0, 0, 1, 0}, '{0, 0, 0, 1}, '{1, 2, 3, 4}, '{3, 0, 0, 0}};
    int unsigned vec_tf [NV][4] = '{
        '{1, 1, 1, 1}, '{1, 1, 1, 1}, '{65536, 65536, 65536, 65536}, '{5, 1, 1, 1},
        '{1, 1, 3, 1}, '{1, 1, 1, 2}, '{1, 1, 1, 1}, '{65536, 1, 1, 1}};
    int unsigned vec_exp [NV][4] = '{
        '{4, 0, 0, 0}, '{1, 65281, 65536, 256}, '{4, 0, 0, 0}, '{10, 10, 10, 10},
        '{3, 65534, 3, 65534}, '{2, 512, 65535, 65025}, '{10, 510, 65535, 65023},
        '{65534, 65534, 65534, 65534}};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] scale(input int unsigned x);
`ifdef INTT_SCALE_EN
        longint unsigned p;
        p = (longint'(x) * 64'd49153) % 64'd65537;
        return N'(p);
`else
        return N'(x);
`endif
    endfunction

    function automatic logic [W-1:0] exp_of(input int idx);
        return {scale(vec_exp[idx][3]), scale(vec_exp[idx][2]),
                scale(vec_exp[idx][1]), scale(vec_exp[idx][0])};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0b required %0b", name, act, req);
        end
    endtask

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d", name,
                     act[N-1:0], act[2*N-1:N], act[3*N-1:2*N], act[4*N-1:3*N],
                     req[N-1:0], req[2*N-1:N], req[3*N-1:2*N], req[4*N-1:3*N]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] dut_out();
        return {bus.A3, bus.A2, bus.A1, bus.A0};
    endfunction

    // driver: present vector idx until accepted; push expected at transfer
    task automatic send(input int idx);
        int waited;
        bus.in_valid = 1'b1;
        bus.a0  = N'(vec_a[idx][0]);
        bus.a1  = N'(vec_a[idx][1]);
        bus.a2  = N'(vec_a[idx][2]);
        bus.a3  = N'(vec_a[idx][3]);
        bus.tf0 = N'(vec_tf[idx][0]);
        bus.tf1 = N'(vec_tf[idx][1]);
        bus.tf2 = N'(vec_tf[idx][2]);
        bus.tf3 = N'(vec_tf[idx][3]);
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp_of(idx));
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 60) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: vector %0d not accepted after %0d cycles, in_ready=%0b required 1",
                         idx, waited, bus.in_ready);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 10);
        check_int(name, lat, LAT);
    endtask

    // scoreboard monitor: compare every output transfer against the queue
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            mon_got = dut_out();
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out_unexpected: got A=%0d,%0d,%0d,%0d with no result outstanding",
                         bus.A0, bus.A1, bus.A2, bus.A3);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("out_data", mon_got, mon_exp);
            end
        end
    end

    initial begin
        int c0;
        int n;
        logic [W-1:0] held;
        logic ghost;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
        bus.tf0 = '0; bus.tf1 = '0; bus.tf2 = '0; bus.tf3 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_val("rst_A", dut_out(), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // first input after reset: nominal latency, basic sum
        send(0);
        check_latency("latency_first");
        wait_empty("basic");

        // back-to-back stream of every vector: one transfer per cycle
        c0 = cyc;
        for (int i = 0; i < NV; i++) send(i);
        check_int("throughput_cycles", cyc - c0, NV);
        wait_empty("stream");

        // bubbles between vectors
        send(1);
        repeat (2) @(posedge clk);
        #1;
        send(5);
        @(posedge clk);
        #1;
        send(6);
        wait_empty("bubbles");

        // backpressure: three vectors, downstream blocked five cycles
        bus.out_ready = 1'b0;
        fork
            begin
                send(3);
                send(4);
                send(6);
            end
        join_none
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check_bit("bp_out_valid", bus.out_valid, 1'b1);
        held = dut_out();
        repeat (5) begin
            check_bit("bp_in_ready", bus.in_ready, 1'b0);
            check_bit("bp_valid_hold", bus.out_valid, 1'b1);
            check_val("bp_A_hold", dut_out(), held);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait fork;
        wait_empty("backpressure");

        // random downstream readiness over the full vector set
        fork
            begin
                for (int i = 0; i < NV; i++) send(i);
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_empty("random_ready");

        // reset shortly after an input transfer: that input never emerges
        send(6);
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_bit("midrst_out_valid", bus.out_valid, 1'b0);
        check_bit("midrst_in_ready", bus.in_ready, 1'b1);
        check_val("midrst_A", dut_out(), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ghost = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ghost = ghost | bus.out_valid;
        end
        check_bit("midrst_no_output", ghost, 1'b0);
        check_val("midrst_A_after", dut_out(), '0);
        @(posedge clk);
        #1;

        // first input after mid-run reset: nominal latency again
        send(2);
        check_latency("latency_after_reset");
        wait_empty("post_reset");

        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
